ext_int_controller: RTL and testbench

//  Downstream consumer of the external-interrupt edge stage: turns its toggle-style flags
//  (a change of level marks one event) into sticky pending bits (EIFR image).

---
 rtl/ext_int_pkg.sv | 18 +
 rtl/int_toggle_detect.sv | 25 ++
 rtl/ext_int_controller.sv | 127 ++++++++++++
 tb/tb_ext_int_controller.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_int_pkg.sv
// Shared definitions for the external-interrupt controller: FSM encodings,
// source index constants and default sizing.
package ext_int_pkg;

    localparam int DEFAULT_NUM_SRC = 4;
    localparam int DEFAULT_VEC_W   = 2;

    // Source indices; a lower index means a higher priority.
    localparam int INT0 = 0;
    localparam int INT1 = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/int_toggle_detect.sv
// Converts toggle-style flags into one-cycle event strobes: each level change
// on a source, relative to the value seen at the previous edge, is one event.
module int_toggle_detect #(
    parameter int NUM_SRC = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] i_toggle,
    output logic [NUM_SRC-1:0] o_evt
);

    logic [NUM_SRC-1:0] r_hist;

    // Remember the toggle levels sampled at the last edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist <= '0;
        end else begin
            r_hist <= i_toggle;
        end
    end

    assign o_evt = i_toggle ^ r_hist;

endmodule

// File: rtl/ext_int_controller.sv
// External interrupt controller: sticky pending flags, per-source and global
// masking, fixed lowest-index-first priority, and a req/ack/done handshake to
// the CPU trap unit.
//
// Handshake: irq_req rises with irq_vec already valid and holds irq_vec
// stable until either irq_ack is seen high on an edge (request consumed, the
// source's pending bit clears, in_service rises) or the request is withdrawn
// because its source is no longer active or gie dropped. irq_ack outside a
// request and irq_done outside service are ignored.
module ext_int_controller
    import ext_int_pkg::*;
#(
    parameter int NUM_SRC = DEFAULT_NUM_SRC,
    parameter int VEC_W   = DEFAULT_VEC_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_toggle,
    input  logic [NUM_SRC-1:0] src_en,
    input  logic               gie,
    input  logic [NUM_SRC-1:0] flag_clr,
    input  logic               irq_ack,
    input  logic               irq_done,
    output logic [NUM_SRC-1:0] pending,
    output logic               irq_req,
    output logic [VEC_W-1:0]   irq_vec,
    output logic               in_service,
    output logic [1:0]         dbg_state
);

    logic [NUM_SRC-1:0] w_evt;
    logic [NUM_SRC-1:0] w_active;
    logic [NUM_SRC-1:0] w_vec_mask;
    logic [NUM_SRC-1:0] w_ack_clr;
    logic               w_any;
    logic               w_vec_live;
    logic [VEC_W-1:0]   w_sel;

    logic [NUM_SRC-1:0] r_pending;
    state_t             r_state;
    logic               r_req;
    logic [VEC_W-1:0]   r_vec;
    logic               r_in_service;

    int_toggle_detect #(
        .NUM_SRC (NUM_SRC)
    ) u_detect (
        .clk      (clk),
        .reset    (reset),
        .i_toggle (src_toggle),
        .o_evt    (w_evt)
    );

    assign w_active   = r_pending & src_en;
    assign w_any      = |w_active;
    assign w_vec_mask = NUM_SRC'(1) << r_vec;
    assign w_vec_live = |(w_active & w_vec_mask);
    assign w_ack_clr  = ((r_state == ST_REQ) && irq_ack) ? w_vec_mask : '0;

    // Priority encoder: lowest active index wins, scanning down to INT0.
    always_comb begin
        w_sel = '0;
        for (int i = NUM_SRC - 1; i >= INT0; i--) begin
            if (w_active[i]) begin
                w_sel = VEC_W'(i);
            end
        end
    end

    // Sticky pending flags; a new event on a bit overrides any clear of it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_evt | (r_pending & ~(flag_clr | w_ack_clr));
        end
    end

    // Request FSM with registered req/vec/in_service outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_req        <= 1'b0;
            r_vec        <= '0;
            r_in_service <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (gie && w_any) begin
                        r_vec   <= w_sel;
                        r_req   <= 1'b1;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Ack takes priority: no preemption by newer sources.
                    if (irq_ack) begin
                        r_req        <= 1'b0;
                        r_in_service <= 1'b1;
                        r_state      <= ST_SERVICE;
                    end else if (!w_vec_live || !gie) begin
                        r_req   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_SERVICE: begin
                    if (irq_done) begin
                        r_in_service <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_req        <= 1'b0;
                    r_in_service <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign pending    = r_pending;
    assign irq_req    = r_req;
    assign irq_vec    = r_vec;
    assign in_service = r_in_service;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_ext_int_controller.sv
// Bench for ext_int_controller: an event-level reference model tracks the
// expected pending set and request/service status; a compare process checks
// the DUT against it every cycle, and directed scenarios pin literal values.
module tb_ext_int_controller;

    logic       clk;
    logic       reset;
    logic [3:0] src_toggle;
    logic [3:0] src_en;
    logic       gie;
    logic [3:0] flag_clr;
    logic       irq_ack;
    logic       irq_done;
    logic [3:0] pending;
    logic       irq_req;
    logic [1:0] irq_vec;
    logic       in_service;
    logic [1:0] dbg_state;

    int checks   = 0;
    int failures = 0;

    ext_int_controller #(
        .NUM_SRC (4),
        .VEC_W   (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .src_toggle (src_toggle),
        .src_en     (src_en),
        .gie        (gie),
        .flag_clr   (flag_clr),
        .irq_ack    (irq_ack),
        .irq_done   (irq_done),
        .pending    (pending),
        .irq_req    (irq_req),
        .irq_vec    (irq_vec),
        .in_service (in_service),
        .dbg_state  (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the CPU should see, tracked as events.
    logic [3:0] m_seen;      // last toggle levels observed
    logic [3:0] m_pend;      // sources with an unserviced event
    logic       m_asking;    // a request is outstanding
    logic       m_serving;   // CPU is inside a handler
    int         m_vec;       // source most recently offered
    logic [3:0] m_evt;
    logic [3:0] m_clr;
    int         m_best;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_seen    = '0;
            m_pend    = '0;
            m_asking  = 1'b0;
            m_serving = 1'b0;
            m_vec     = 0;
        end else begin
            m_evt  = src_toggle ^ m_seen;
            m_seen = src_toggle;
            m_clr  = flag_clr;
            if (m_asking) begin
                if (irq_ack) begin
                    m_clr[m_vec] = 1'b1;
                    m_asking     = 1'b0;
                    m_serving    = 1'b1;
                end else if (!gie || !(m_pend[m_vec] && src_en[m_vec])) begin
                    m_asking = 1'b0;
                end
            end else if (m_serving) begin
                if (irq_done) m_serving = 1'b0;
            end else if (gie) begin
                m_best = -1;
                for (int i = 3; i >= 0; i--) begin
                    if (m_pend[i] && src_en[i]) m_best = i;
                end
                if (m_best >= 0) begin
                    m_asking = 1'b1;
                    m_vec    = m_best;
                end
            end
            m_pend = (m_pend & ~m_clr) | m_evt;
        end
    end

    // Scoreboard compare, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            chk("cmp_pending",    pending,           m_pend);
            chk("cmp_irq_req",    {3'b0, irq_req},   {3'b0, m_asking});
            chk("cmp_irq_vec",    {2'b0, irq_vec},   4'(m_vec));
            chk("cmp_in_service", {3'b0, in_service}, {3'b0, m_serving});
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ack_pulse();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic done_pulse();
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        src_toggle = '0;
        src_en     = '0;
        gie        = 1'b0;
        flag_clr   = '0;
        irq_ack    = 1'b0;
        irq_done   = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_pending", pending, 4'h0);
        chk("rst_irq_req", {3'b0, irq_req}, 4'h0);
        chk("rst_irq_vec", {2'b0, irq_vec}, 4'h0);
        chk("rst_in_service", {3'b0, in_service}, 4'h0);

        // 1: single event on INT0
        src_en = 4'h1; gie = 1'b1; src_toggle ^= 4'h1;
        tick();
        chk("t1_pending", pending, 4'h1);
        chk("t1_req_early", {3'b0, irq_req}, 4'h0);
        tick();
        chk("t1_req", {3'b0, irq_req}, 4'h1);
        chk("t1_vec", {2'b0, irq_vec}, 4'h0);
        ack_pulse();
        chk("t1_pend_ack", pending, 4'h0);
        chk("t1_in_service", {3'b0, in_service}, 4'h1);
        done_pulse();
        chk("t1_done", {3'b0, in_service}, 4'h0);

        // 2: two simultaneous sources, priority order
        src_en = 4'hF; src_toggle ^= 4'h6;
        tick();
        chk("t2_pending", pending, 4'h6);
        tick();
        chk("t2_vec1", {2'b0, irq_vec}, 4'h1);
        ack_pulse();
        chk("t2_pend_after_ack", pending, 4'h4);
        done_pulse();
        chk("t2_req_idle", {3'b0, irq_req}, 4'h0);
        tick();
        chk("t2_req2", {3'b0, irq_req}, 4'h1);
        chk("t2_vec2", {2'b0, irq_vec}, 4'h2);
        ack_pulse();
        done_pulse();

        // 3: masked source, then enabled
        src_en = 4'h0; src_toggle ^= 4'h1;
        tick();
        chk("t3_pending", pending, 4'h1);
        repeat (2) tick();
        chk("t3_masked", {3'b0, irq_req}, 4'h0);
        src_en = 4'h1;
        tick();
        chk("t3_req", {3'b0, irq_req}, 4'h1);

        // 4: withdraw via flag_clr while requesting
        flag_clr = 4'h1;
        tick();
        flag_clr = 4'h0;
        chk("t4_pending", pending, 4'h0);
        tick();
        chk("t4_req", {3'b0, irq_req}, 4'h0);
        chk("t4_state", {2'b0, dbg_state}, 4'h0);

        // 5: set beats clear, set beats ack-clear
        src_en = 4'h0; src_toggle ^= 4'h1; flag_clr = 4'h1;
        tick();
        flag_clr = 4'h0;
        chk("t5_set_vs_clr", pending, 4'h1);
        flag_clr = 4'h1;
        tick();
        flag_clr = 4'h0;
        chk("t5_clr", pending, 4'h0);
        src_en = 4'h1; src_toggle ^= 4'h1;
        repeat (2) tick();
        chk("t5_req", {3'b0, irq_req}, 4'h1);
        src_toggle ^= 4'h1;
        ack_pulse();
        chk("t5_set_vs_ack", pending, 4'h1);
        chk("t5_in_service", {3'b0, in_service}, 4'h1);
        done_pulse();
        tick();
        chk("t5_rereq", {3'b0, irq_req}, 4'h1);
        ack_pulse();
        done_pulse();

        // 6: asynchronous reset in SERVICE
        src_en = 4'hF; src_toggle ^= 4'h2;
        repeat (2) tick();
        ack_pulse();
        src_toggle ^= 4'hA;
        tick();
        chk("t6_pend_pre", pending, 4'hA);
        chk("t6_svc_pre", {3'b0, in_service}, 4'h1);
        #3 reset = 1'b1;
        #1;
        chk("t6_rst_pending", pending, 4'h0);
        chk("t6_rst_in_service", {3'b0, in_service}, 4'h0);
        chk("t6_rst_irq_req", {3'b0, irq_req}, 4'h0);
        chk("t6_rst_irq_vec", {2'b0, irq_vec}, 4'h0);
        src_toggle = 4'h0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (4) tick();
        chk("t6_quiet_req", {3'b0, irq_req}, 4'h0);
        chk("t6_quiet_pend", pending, 4'h0);
        src_toggle ^= 4'h8;
        repeat (2) tick();
        chk("t6_new_req", {3'b0, irq_req}, 4'h1);
        chk("t6_new_vec", {2'b0, irq_vec}, 4'h3);
        ack_pulse();
        done_pulse();
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
